// File: rtl/rotate_pkg.sv
// Shared types and Q10 constants for the inverse fixed-angle rotator.
// Also holds the shift-and-saturate helper that every rotation step uses.
package rotate_pkg;

  localparam int FRAC    = 10;
  localparam int SIN_Q10 = 89;
  localparam int COS_Q10 = 1020;

  typedef logic signed [9:0]  coord_t;
  typedef logic signed [20:0] acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } rot_state_e;

  // Floor-shift a Q10 product back to integer coordinates and clamp to 10-bit range.
  function automatic coord_t shift_sat(input acc_t v);
    acc_t sh;
    sh = v >>> FRAC;
    if (sh > 21'sd511) begin
      shift_sat = 10'sd511;
    end else if (sh < -21'sd512) begin
      shift_sat = 10'sh200;
    end else begin
      shift_sat = sh[9:0];
    end
  endfunction

endpackage

// File: rtl/rotate_inv_step.sv
// One combinational inverse-rotation step: (x,y) -> (x*COS - y*SIN, y*COS + x*SIN) >>> 10,
// saturated to the signed 10-bit coordinate range.
module rotate_inv_step
  import rotate_pkg::*;
#(
  parameter int SIN = SIN_Q10,
  parameter int COS = COS_Q10
) (
  input  coord_t i_x,
  input  coord_t i_y,
  output coord_t o_nx,
  output coord_t o_ny
);

  localparam acc_t SIN_A = acc_t'(SIN);
  localparam acc_t COS_A = acc_t'(COS);

  acc_t w_x;
  acc_t w_y;
  acc_t w_px;
  acc_t w_py;

  // 21 bits hold |512*1020 + 512*89| without overflow.
  always_comb begin
    w_x  = acc_t'(i_x);
    w_y  = acc_t'(i_y);
    w_px = (w_x * COS_A) - (w_y * SIN_A);
    w_py = (w_y * COS_A) + (w_x * SIN_A);
    o_nx = shift_sat(w_px);
    o_ny = shift_sat(w_py);
  end

endmodule

// File: rtl/rotate_inv_seq.sv
// Sequential inverse rotator: applies steps_i inverse rotation steps, one per clock,
// between a valid/ready request port and a valid/ready result port.
module rotate_inv_seq
  import rotate_pkg::*;
#(
  parameter int SIN     = SIN_Q10,
  parameter int COS     = COS_Q10,
  parameter int STEPS_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  coord_t             x_i,
  input  coord_t             y_i,
  input  logic [STEPS_W-1:0] steps_i,
  output logic               out_valid,
  input  logic               out_ready,
  output coord_t             x_o,
  output coord_t             y_o,
  output logic               busy
);

  rot_state_e         r_state;
  coord_t             r_x;
  coord_t             r_y;
  logic [STEPS_W-1:0] r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  coord_t w_nx;
  coord_t w_ny;

  rotate_inv_step #(
    .SIN (SIN),
    .COS (COS)
  ) u_step (
    .i_x  (r_x),
    .i_y  (r_y),
    .o_nx (w_nx),
    .o_ny (w_ny)
  );

  // Control FSM with registered handshake flags; x/y registers double as the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_x         <= 10'sd0;
      r_y         <= 10'sd0;
      r_cnt       <= {STEPS_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x        <= x_i;
            r_y        <= y_i;
            r_cnt      <= steps_i;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (steps_i != {STEPS_W{1'b0}}) begin
              r_state <= ROT;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        ROT: begin
          r_x   <= w_nx;
          r_y   <= w_ny;
          r_cnt <= r_cnt - STEPS_W'(1);
          // The last step lands on the same edge that raises out_valid.
          if (r_cnt == STEPS_W'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= {STEPS_W{1'b0}};
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign x_o       = r_x;
  assign y_o       = r_y;

endmodule

// File: tb/tb_rotate_inv_seq.sv
// Scoreboard bench for rotate_inv_seq: expected results are queued at request time
// and compared when the result handshake completes.
module tb_rotate_inv_seq;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [9:0] x_i;
  logic signed [9:0] y_i;
  logic [3:0]        steps_i;
  logic              out_valid;
  logic              out_ready;
  logic signed [9:0] x_o;
  logic signed [9:0] y_o;
  logic              busy;

  typedef struct {
    int x;
    int y;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   last_x  = 0;
  int   last_y  = 0;

  rotate_inv_seq #(.SIN(89), .COS(1020), .STEPS_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_i       (x_i),
    .y_i       (y_i),
    .steps_i   (steps_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_o       (x_o),
    .y_o       (y_o),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat10(input int v);
    if (v > 511) return 511;
    else if (v < -512) return -512;
    else return v;
  endfunction

  function automatic void inv_model(input int x, input int y, input int k, output int rx, output int ry);
    int cx = x;
    int cy = y;
    int nx;
    int ny;
    for (int i = 0; i < k; i++) begin
      nx = sat10((cx * 1020 - cy * 89) >>> 10);
      ny = sat10((cy * 1020 + cx * 89) >>> 10);
      cx = nx;
      cy = ny;
    end
    rx = cx;
    ry = cy;
  endfunction

  function automatic void fwd_model(input int x, input int y, input int k, output int rx, output int ry);
    int cx = x;
    int cy = y;
    int nx;
    int ny;
    for (int i = 0; i < k; i++) begin
      nx = sat10((cx * 1020 + cy * 89) >>> 10);
      ny = sat10((cy * 1020 - cx * 89) >>> 10);
      cx = nx;
      cy = ny;
    end
    rx = cx;
    ry = cy;
  endfunction

  // Result-side scoreboard: compare on every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check_eq("sb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("x_o", int'(x_o), e.x);
        check_eq("y_o", int'(y_o), e.y);
      end
      last_x = int'(x_o);
      last_y = int'(y_o);
    end
  end

  task automatic push_exp(input int ex, input int ey);
    exp_t e;
    e.x = ex;
    e.y = ey;
    exp_q.push_back(e);
  endtask

  // Present a request and return just after the accepting edge; inputs then get scrambled.
  task automatic issue(input int x, input int y, input int steps);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    x_i      = x[9:0];
    y_i      = y[9:0];
    steps_i  = steps[3:0];
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("accept", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_i      = 10'($urandom);
    y_i      = 10'($urandom);
    steps_i  = 4'($urandom);
  endtask

  task automatic wait_out(input int steps);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", lat, steps + 1);
  endtask

  task automatic wait_drop();
    int n = 0;
    while (out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("out_drop", int'(out_valid), 0);
  endtask

  task automatic send(input int x, input int y, input int steps, input int ex, input int ey);
    push_exp(ex, ey);
    issue(x, y, steps);
    wait_out(steps);
    wait_drop();
  endtask

  initial begin
    int ex;
    int ey;
    int fx;
    int fy;
    int ox;
    int oy;
    int ks[3];
    int seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x_i       = 10'sd0;
    y_i       = 10'sd0;
    steps_i   = 4'd0;
    out_ready = 1'b1;
    #23 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_x_o", int'(x_o), 0);
    check_eq("rst_y_o", int'(y_o), 0);

    // Directed points with hand-computed results.
    send(100, 0, 0, 100, 0);
    send(400, 0, 1, 398, 34);
    send(-1, 0, 1, -1, -1);
    send(511, -512, 1, 511, -466);

    // Full-range random requests, including saturation cases.
    for (int i = 0; i < 6; i++) begin
      ox = int'($urandom_range(1023)) - 512;
      oy = int'($urandom_range(1023)) - 512;
      fx = (i == 0) ? 15 : int'($urandom_range(15));
      inv_model(ox, oy, fx, ex, ey);
      send(ox, oy, fx, ex, ey);
    end

    // Round trip through the forward rotator.
    ks[0] = 1;
    ks[1] = 4;
    ks[2] = 15;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) begin
        ox = int'($urandom_range(600)) - 300;
        oy = int'($urandom_range(600)) - 300;
        fwd_model(ox, oy, ks[j], fx, fy);
        inv_model(fx, fy, ks[j], ex, ey);
        send(fx, fy, ks[j], ex, ey);
        check_eq("rt_err_x", int'((last_x - ox) <= 2 * ks[j] + 2 && (ox - last_x) <= 2 * ks[j] + 2), 1);
        check_eq("rt_err_y", int'((last_y - oy) <= 2 * ks[j] + 2 && (oy - last_y) <= 2 * ks[j] + 2), 1);
      end
    end

    // Backpressure: result held in DONE while a competing request is presented.
    out_ready = 1'b0;
    inv_model(200, -150, 2, ex, ey);
    push_exp(ex, ey);
    issue(200, -150, 2);
    wait_out(2);
    in_valid = 1'b1;
    x_i      = 10'sd5;
    y_i      = 10'sd7;
    steps_i  = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_x_o", int'(x_o), ex);
      check_eq("bp_y_o", int'(y_o), ey);
      check_eq("bp_out_valid", int'(out_valid), 1);
      check_eq("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_rel_out_valid", int'(out_valid), 0);
    check_eq("bp_rel_in_ready", int'(in_ready), 1);
    check_eq("bp_rel_busy", int'(busy), 0);
    check_eq("bp_sb_empty", exp_q.size(), 0);

    // Reset during the third ROT cycle of an 8-step request.
    issue(-300, 250, 8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", int'(out_valid), 0);
    check_eq("abort_in_ready", int'(in_ready), 1);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_x_o", int'(x_o), 0);
    check_eq("abort_y_o", int'(y_o), 0);
    #7 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check_eq("abort_no_pulse", seen, 0);
    inv_model(-300, 250, 8, ex, ey);
    send(-300, 250, 8, ex, ey);
    check_eq("final_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
